clk_freq_meter: RTL and testbench

- Measures an incoming slow clock or tick, such as the 500 Hz output of the board clock divider or any external square wave.
- Counts rising edges of sig_in over a fixed gate window of board-clock cycles, and measures the edge-to-edge period.
- Publishes both results with a one-cycle valid strobe for display or checking logic.
- It is the measuring end of the divided-clock path: the divider generates a frequency, this block reports it.

---
 rtl/clk_freq_meter.sv | 119 +++++++++++
 tb/tb_clk_freq_meter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_meter.sv
// rtl/clk_freq_meter.sv - gated rising-edge counter and edge-to-edge period meter for a slow clock or tick
module clk_freq_meter #(
  parameter int BOARD_CLK   = 100000000,
  parameter int GATE_CYCLES = BOARD_CLK,
  parameter int CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_cnt,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             overflow,
  output logic             no_signal
);

  localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, GATE} state_t;

  state_t            state;
  logic              s1, s2, s3;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  per_cnt;
  logic              sat;
  logic              armed;

  logic              edge_det;
  logic              terminal;
  logic [CNT_W-1:0]  edge_cnt_nxt;
  logic              sat_nxt;
  logic [CNT_W-1:0]  per_cnt_inc;

  assign edge_det    = s2 & ~s3;
  assign terminal    = (gate_cnt == GATE_LAST);
  assign per_cnt_inc = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CNT_W'(1);

  // Count including the current cycle's edge, so the terminal cycle's edge lands in the closing window.
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;
    if (edge_det) begin
      if (edge_cnt == CNT_MAX) sat_nxt = 1'b1;
      else                     edge_cnt_nxt = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      per_cnt    <= '0;
      sat        <= 1'b0;
      armed      <= 1'b0;
      freq_cnt   <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      overflow   <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          per_cnt  <= '0;
          sat      <= 1'b0;
          armed    <= 1'b0;
          if (enable) state <= GATE;
        end
        GATE: begin
          if (!enable) begin
            // Abandon the partial window; published results keep their last values.
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            per_cnt  <= '0;
            sat      <= 1'b0;
            armed    <= 1'b0;
          end else begin
            if (edge_det) begin
              if (armed) period <= per_cnt_inc;
              per_cnt <= '0;
              armed   <= 1'b1;
            end else begin
              per_cnt <= per_cnt_inc;
            end
            if (terminal) begin
              freq_cnt   <= edge_cnt_nxt;
              overflow   <= sat_nxt;
              no_signal  <= (edge_cnt_nxt == '0);
              meas_valid <= 1'b1;
              gate_cnt   <= '0;
              edge_cnt   <= '0;
              sat        <= 1'b0;
            end else begin
              gate_cnt <= gate_cnt + GATE_W'(1);
              edge_cnt <= edge_cnt_nxt;
              sat      <= sat_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb/tb_clk_freq_meter.sv - randomized self-checking bench for clk_freq_meter against an edge-list reference model
module tb_clk_freq_meter;

  localparam int GC   = 200;
  localparam int CW   = 6;
  localparam int MAXV = (1 << CW) - 1;
  localparam int BIG  = 32'h7fffffff;

  logic          clk_in  = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable  = 1'b0;
  logic          sig_in  = 1'b0;
  logic [CW-1:0] freq_cnt;
  logic [CW-1:0] period;
  logic          meas_valid;
  logic          overflow;
  logic          no_signal;

  clk_freq_meter #(
    .BOARD_CLK  (1000),
    .GATE_CYCLES(GC),
    .CNT_W      (CW)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .sig_in    (sig_in),
    .freq_cnt  (freq_cnt),
    .period    (period),
    .meas_valid(meas_valid),
    .overflow  (overflow),
    .no_signal (no_signal)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Reference model: cycle numbers of upcoming edges, edges accepted in the current run, expected outputs.
  int pend[$];
  int run_edges[$];
  bit run_valid  = 1'b0;
  int g_start    = 0;
  int stop_cyc   = BIG;
  bit last_sig   = 1'b0;
  int ph         = 0;
  int exp_freq   = 0;
  int exp_period = 0;
  bit exp_ovf    = 1'b0;
  bit exp_nosig  = 1'b0;
  bit exp_mv     = 1'b0;

  function automatic int satv(int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, int exp_v);
    checks++;
    assert (obs === 32'(exp_v)) passes++;
    else $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp_v, cyc);
  endtask

  task automatic step();
    int n;
    @(posedge clk_in);
    #1;
    cyc++;
    exp_mv = 1'b0;
    if (pend.size() > 0 && pend[0] == cyc - 1) begin
      void'(pend.pop_front());
      if (run_valid && cyc - 1 >= g_start && cyc - 1 < stop_cyc) begin
        run_edges.push_back(cyc - 1);
        if (run_edges.size() >= 2)
          exp_period = satv(run_edges[run_edges.size()-1] - run_edges[run_edges.size()-2]);
      end
    end
    if (run_valid && cyc > g_start && (cyc - g_start) % GC == 0 && cyc - 1 < stop_cyc) begin
      n = 0;
      foreach (run_edges[i]) if (run_edges[i] >= cyc - GC) n++;
      exp_mv    = 1'b1;
      exp_freq  = satv(n);
      exp_ovf   = (n > MAXV);
      exp_nosig = (n == 0);
    end
    chk("meas_valid", 32'(meas_valid), int'(exp_mv));
    chk("freq_cnt",   32'(freq_cnt),   exp_freq);
    chk("overflow",   32'(overflow),   int'(exp_ovf));
    chk("no_signal",  32'(no_signal),  int'(exp_nosig));
    chk("period",     32'(period),     exp_period);
  endtask

  task automatic drive_sig(bit v);
    if (v && !last_sig) pend.push_back(cyc + 2);
    last_sig = v;
    sig_in   = v;
  endtask

  task automatic set_en(bit v);
    if (v && !enable) begin
      g_start   = cyc + 1;
      stop_cyc  = BIG;
      run_valid = 1'b1;
      run_edges.delete();
    end
    if (!v && enable) stop_cyc = cyc;
    enable = v;
  endtask

  task automatic run_sq(int n, int hi, int lo);
    for (int i = 0; i < n; i++) begin
      step();
      drive_sig(ph < hi);
      ph = (ph + 1) % (hi + lo);
    end
  endtask

  task automatic run_to_gate(int pos, int hi, int lo);
    for (int i = 0; i < GC + 1; i++) begin
      if ((cyc - g_start) % GC == pos && cyc > g_start + GC) break;
      run_sq(1, hi, lo);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    run_edges.delete();
    run_valid  = 1'b0;
    stop_cyc   = BIG;
    last_sig   = 1'b0;
    ph         = 0;
    exp_freq   = 0;
    exp_period = 0;
    exp_ovf    = 1'b0;
    exp_nosig  = 1'b0;
    exp_mv     = 1'b0;
  endtask

  initial begin
    // Cold start under reset.
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    run_sq(2, 0, 1);
    set_en(1'b1);

    // Regular square wave: 10 edges per window, period 20.
    run_sq(650, 10, 10);

    // Idle line, low then high.
    run_sq(400, 0, 1);
    run_sq(400, 1, 0);

    // Edge-count saturation, then recovery with a slower wave.
    run_sq(400, 1, 1);
    run_sq(600, 20, 20);

    // Period counter saturation.
    run_sq(400, 40, 40);

    // Enable gap mid-window.
    run_to_gate(100, 7, 7);
    set_en(1'b0);
    run_sq(20, 7, 7);
    set_en(1'b1);
    run_sq(450, 7, 7);

    // Randomized duty and frequency segments.
    for (int s = 0; s < 6; s++)
      run_sq(int'($urandom_range(100, 500)), int'($urandom_range(1, 30)), int'($urandom_range(1, 30)));

    // Asynchronous reset mid-window.
    run_to_gate(140, 12, 8);
    #3;
    reset_n = 1'b0;
    sig_in  = 1'b0;
    enable  = 1'b0;
    model_reset();
    #1;
    chk("rst_freq_cnt",   32'(freq_cnt),   0);
    chk("rst_period",     32'(period),     0);
    chk("rst_meas_valid", 32'(meas_valid), 0);
    chk("rst_overflow",   32'(overflow),   0);
    chk("rst_no_signal",  32'(no_signal),  0);
    for (int i = 0; i < 3; i++) begin
      step();
      drive_sig(1'b0);
    end
    reset_n = 1'b1;
    run_sq(1, 0, 1);
    set_en(1'b1);
    run_sq(450, 12, 8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
